rgb_yuv_encoder: RTL and testbench
==================================

Name: rgb_yuv_encoder

Overview:
- Converts a raster-order 320x240 RGB pixel stream to YUV (BT.601 integer).
- Decimates U/V horizontally by 2 (2-tap rounded average).
- Writes packed Y, U and V words into SRAM using the layout the colourspace/upsampling datapath reads: Y at 0, U at 38400, V at 57600, two samples per word, even sample in the high byte.
- Sits between a pixel source (test pattern or camera path) and SRAM_Controller's write port. It is the encoder/writer counterpart of the YUV-to-RGB reader.

Parameters:
Y_OFFSET, 18'd0, base word address of the Y plane
U_OFFSET, 18'd38400, base word address of the U plane
V_OFFSET, 18'd57600, base word address of the V plane
NUM_GROUPS, 15'd19200, 4-pixel groups per frame (320*240/4)

Ports:
Clock_50  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; ignored unless in S_IDLE
done  out  1  one-cycle pulse after the final V word write
busy  out  1  high in every state except S_IDLE
pix_valid  in  1  source has a pixel on pix_R/G/B
pix_ready  out  1  encoder accepts a pixel this cycle; transfer occurs when valid&ready
pix_R  in  8  red
pix_G  in  8  green
pix_B  in  8  blue
SRAM_address  out  18  word address to SRAM_Controller
SRAM_write_data  out  16  packed write data
SRAM_we_n  out  1  active-low write enable, one cycle per word

Behaviour:
- Reset (async, immediate) values: state=S_IDLE, all outputs 0 except SRAM_we_n=1, pix_ready=0; y_addr=0, uv_addr=0.
- A reset mid-frame abandons the frame. No further writes occur. The next start restarts at address 0.
- pix_ready is combinational from state: 1 in S_P0..S_P3, 0 elsewhere.
- SRAM_address, SRAM_write_data and SRAM_we_n are registered. A write issued on edge k is presented for exactly the cycle after edge k.
- SRAM_we_n returns to 1 on every edge that issues no write.
- Conversion is per accepted pixel, combinational, and registered on acceptance. Intermediates are signed, at least 18 bits; >>> is an arithmetic (floor) shift:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - U = ((-38R - 74G + 112B + 128) >>> 8) + 128
  - V = ((112R - 94G - 18B + 128) >>> 8) + 128
  - Results are truncated to 8 bits. No clipping is needed; the range is 16..240.
- Decimation per pixel pair (e,o): Ud = (Ue + Uo + 1) >> 1; Vd likewise. Use a 9-bit sum.
- Packing:
  - Y word = {Y_even, Y_odd}
  - U word = {Ud pair0, Ud pair1}
  - V word = {Vd pair0, Vd pair1}
- State machine (transitions in S_P0..S_P3 occur only on valid&ready; otherwise the state holds and no write is issued):
  - S_IDLE: on start -> S_P0; clear y_addr and uv_addr.
  - S_P0: capture p0 -> S_P1.
  - S_P1: capture p1; issue write Y_OFFSET+y_addr <= {Y0,Y1}; y_addr++; store Ud0/Vd0 -> S_P2.
  - S_P2: capture p2 -> S_P3.
  - S_P3: capture p3; issue write Y_OFFSET+y_addr <= {Y2,Y3}; y_addr++ -> S_WU.
  - S_WU: issue write U_OFFSET+uv_addr <= {Ud0,Ud1} -> S_WV.
  - S_WV: issue write V_OFFSET+uv_addr <= {Vd0,Vd1}. If uv_addr==NUM_GROUPS-1 -> S_DONE, else uv_addr++ -> S_P0.
  - S_DONE: done<=1 for one cycle -> S_IDLE.
- Write order per group: Y, Y, U, V.
- Throughput: 4 pixels per 6 cycles with valid held high. Stalls on pix_valid=0 insert no writes and do not change data.
- start asserted in any state other than S_IDLE has no effect.

Test Plan:
- Reset: hold Reset, then release -> SRAM_we_n=1, pix_ready=0, busy=0, done=0. With no start pulse, no write ever occurs.
- One group with valid held high, after start: red(255,0,0), blue(0,0,255), white(255,255,255), black(0,0,0) -> exactly 4 writes, in this order:
  - addr 0 = 16'h5229
  - addr 1 = 16'hEB10
  - addr 38400 = 16'hA580
  - addr 57600 = 16'hAF80
- Same group with pix_valid deasserted for 3 cycles between every pixel -> identical 4 writes, same order. SRAM_we_n=0 only in the 4 write cycles.
- Full frame, all pixels gray (128,128,128), valid always high:
  - 76800 writes; last addresses are 38399, 57599 and 76799.
  - Y words 16'h7E7E, U/V words 16'h8080.
  - done pulses once, exactly 115200 accepted-pixel/write-state cycles after start (plus the S_DONE cycle).
- Reset mid-frame after 10 groups -> SRAM_we_n=1 and pix_ready=0 asynchronously. A new start then writes the first Y word to addr 0.
- start pulse while busy (mid-group) -> no restart and no address change. The frame completes normally with a single done.

Source files
------------

// File: rtl/rgb_yuv_encoder.sv
// RGB-to-YUV (BT.601 integer) frame encoder: converts a raster pixel stream, decimates U/V
// horizontally by 2 and writes packed Y/U/V planes through the SRAM controller write port.
module rgb_yuv_encoder #(
  parameter logic [17:0] Y_OFFSET   = 18'd0,
  parameter logic [17:0] U_OFFSET   = 18'd38400,
  parameter logic [17:0] V_OFFSET   = 18'd57600,
  parameter logic [14:0] NUM_GROUPS = 15'd19200
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_R,
  input  logic [7:0]  pix_G,
  input  logic [7:0]  pix_B,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
  // pix_ready depends only on state, never on pix_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_WU, S_WV, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] y_addr_q, y_addr_d;
  logic [14:0] uv_addr_q, uv_addr_d;
  logic [7:0]  y_hold_q, y_hold_d, u_hold_q, u_hold_d, v_hold_q, v_hold_d;
  logic [7:0]  ud0_q, ud0_d, vd0_q, vd0_d, ud1_q, ud1_d, vd1_q, vd1_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_wdata_q, sram_wdata_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        done_q, done_d;

  logic signed [17:0] r_s, g_s, b_s;
  logic [7:0]  y_pix, u_pix, v_pix, ud_avg, vd_avg;
  logic        accept;

  assign r_s = $signed({10'd0, pix_R});
  assign g_s = $signed({10'd0, pix_G});
  assign b_s = $signed({10'd0, pix_B});

  // Results always land in 16..240, so truncating to 8 bits never wraps.
  assign y_pix = 8'(((18'sd66 * r_s + 18'sd129 * g_s + 18'sd25 * b_s + 18'sd128) >>> 8) + 18'sd16);
  assign u_pix = 8'(((18'sd112 * b_s - 18'sd38 * r_s - 18'sd74 * g_s + 18'sd128) >>> 8) + 18'sd128);
  assign v_pix = 8'(((18'sd112 * r_s - 18'sd94 * g_s - 18'sd18 * b_s + 18'sd128) >>> 8) + 18'sd128);

  assign ud_avg = 8'(({1'b0, u_hold_q} + {1'b0, u_pix} + 9'd1) >> 1);
  assign vd_avg = 8'(({1'b0, v_hold_q} + {1'b0, v_pix} + 9'd1) >> 1);

  assign pix_ready = (state_q == S_P0) || (state_q == S_P1) ||
                     (state_q == S_P2) || (state_q == S_P3);
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state_q != S_IDLE);

  assign done            = done_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_wdata_q;
  assign SRAM_we_n       = sram_we_n_q;

  always_comb begin
    state_d      = state_q;
    y_addr_d     = y_addr_q;
    uv_addr_d    = uv_addr_q;
    y_hold_d     = y_hold_q;
    u_hold_d     = u_hold_q;
    v_hold_d     = v_hold_q;
    ud0_d        = ud0_q;
    vd0_d        = vd0_q;
    ud1_d        = ud1_q;
    vd1_d        = vd1_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_we_n_d  = 1'b1;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_P0;
          y_addr_d  = '0;
          uv_addr_d = '0;
        end
      end
      S_P0, S_P2: begin
        if (accept) begin
          y_hold_d = y_pix;
          u_hold_d = u_pix;
          v_hold_d = v_pix;
          state_d  = (state_q == S_P0) ? S_P1 : S_P3;
        end
      end
      S_P1, S_P3: begin
        if (accept) begin
          sram_addr_d  = Y_OFFSET + y_addr_q;
          sram_wdata_d = {y_hold_q, y_pix};
          sram_we_n_d  = 1'b0;
          y_addr_d     = y_addr_q + 18'd1;
          if (state_q == S_P1) begin
            ud0_d   = ud_avg;
            vd0_d   = vd_avg;
            state_d = S_P2;
          end else begin
            ud1_d   = ud_avg;
            vd1_d   = vd_avg;
            state_d = S_WU;
          end
        end
      end
      S_WU: begin
        sram_addr_d  = U_OFFSET + {3'd0, uv_addr_q};
        sram_wdata_d = {ud0_q, ud1_q};
        sram_we_n_d  = 1'b0;
        state_d      = S_WV;
      end
      S_WV: begin
        sram_addr_d  = V_OFFSET + {3'd0, uv_addr_q};
        sram_wdata_d = {vd0_q, vd1_q};
        sram_we_n_d  = 1'b0;
        if (uv_addr_q == NUM_GROUPS - 15'd1) begin
          state_d = S_DONE;
        end else begin
          uv_addr_d = uv_addr_q + 15'd1;
          state_d   = S_P0;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      y_addr_q     <= '0;
      uv_addr_q    <= '0;
      y_hold_q     <= '0;
      u_hold_q     <= '0;
      v_hold_q     <= '0;
      ud0_q        <= '0;
      vd0_q        <= '0;
      ud1_q        <= '0;
      vd1_q        <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_we_n_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_addr_q     <= y_addr_d;
      uv_addr_q    <= uv_addr_d;
      y_hold_q     <= y_hold_d;
      u_hold_q     <= u_hold_d;
      v_hold_q     <= v_hold_d;
      ud0_q        <= ud0_d;
      vd0_q        <= vd0_d;
      ud1_q        <= ud1_d;
      vd1_q        <= vd1_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_n_q  <= sram_we_n_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_rgb_yuv_encoder.sv
// Directed bench for rgb_yuv_encoder: hand-computed pixel groups, a shortened gray frame,
// mid-frame reset and start-while-busy, all checked against an expected write queue.
module tb_rgb_yuv_encoder;

  // A 16-group frame keeps the frame-level scenarios short.
  localparam logic [14:0] G      = 15'd16;
  localparam logic [17:0] U_BASE = 18'd38400;
  localparam logic [17:0] V_BASE = 18'd57600;

  logic        Clock_50 = 1'b0;
  logic        Reset    = 1'b0;
  logic        start    = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_R = '0, pix_G = '0, pix_B = '0;
  logic        done, busy, pix_ready, SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int checks = 0, errors = 0, busy_cyc = 0, done_cnt = 0;

  always #10 Clock_50 = ~Clock_50;

  rgb_yuv_encoder #(.NUM_GROUPS(G)) dut (
    .Clock_50(Clock_50), .Reset(Reset), .start(start), .done(done), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n)
  );

  // Write/busy/done monitor sampled mid-cycle.
  always @(negedge Clock_50) begin
    if (!SRAM_we_n) obs_q.push_back({SRAM_address, SRAM_write_data});
    if (busy) busy_cyc++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock_50);
    #1 Reset = 1'b0;
    @(posedge Clock_50);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge Clock_50);
    #1 start = 1'b1;
    @(posedge Clock_50);
    #1 start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int gap);
    bit ok = 0;
    pix_R = r; pix_G = g; pix_B = b;
    pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock_50);
      if (pix_ready) begin ok = 1; break; end
    end
    if (!ok) check_eq("pix_ready_timeout", {63'd0, pix_ready}, 64'd1);
    @(posedge Clock_50);
    #1;
    if (gap > 0) begin
      pix_valid = 1'b0;
      repeat (gap) @(posedge Clock_50);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock_50);
      if (!busy) break;
    end
    check_eq("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock_50);
      #1;
      if (obs_q.size() >= n) break;
    end
    check_eq("write_wait_timeout", 64'(obs_q.size() >= n), 64'd1);
  endtask

  task automatic compare_writes(input string tag);
    check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq(tag, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_group_exp();
    exp_q.push_back({18'd0, 16'h5229});
    exp_q.push_back({18'd1, 16'hEB10});
    exp_q.push_back({U_BASE, 16'hA580});
    exp_q.push_back({V_BASE, 16'hAF80});
  endtask

  task automatic push_gray_frame_exp();
    for (int g = 0; g < int'(G); g++) begin
      exp_q.push_back({18'(2 * g), 16'h7E7E});
      exp_q.push_back({18'(2 * g + 1), 16'h7E7E});
      exp_q.push_back({U_BASE + 18'(g), 16'h8080});
      exp_q.push_back({V_BASE + 18'(g), 16'h8080});
    end
  endtask

  task automatic run_group(input string tag, input int gap);
    do_reset();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    send_pixel(8'd255, 8'd0,   8'd0,   gap);
    send_pixel(8'd0,   8'd0,   8'd255, gap);
    send_pixel(8'd255, 8'd255, 8'd255, gap);
    send_pixel(8'd0,   8'd0,   8'd0,   gap);
    pix_valid = 1'b0;
    repeat (6) @(posedge Clock_50);
    #1;
    push_group_exp();
    compare_writes(tag);
  endtask

  initial begin
    // Reset state and no writes without start.
    do_reset();
    check_eq("rst_we_n",  {63'd0, SRAM_we_n}, 64'd1);
    check_eq("rst_ready", {63'd0, pix_ready}, 64'd0);
    check_eq("rst_busy",  {63'd0, busy}, 64'd0);
    check_eq("rst_done",  {63'd0, done}, 64'd0);
    check_eq("rst_addr",  64'(SRAM_address), 64'd0);
    obs_q.delete();
    pix_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix_R = 8'($urandom_range(0, 255));
      pix_G = 8'($urandom_range(0, 255));
      pix_B = 8'($urandom_range(0, 255));
      @(posedge Clock_50);
      #1;
    end
    pix_valid = 1'b0;
    check_eq("idle_no_write", 64'(obs_q.size()), 64'd0);
    check_eq("idle_ready", {63'd0, pix_ready}, 64'd0);

    // One group, valid held high, then with 3-cycle stalls between pixels.
    run_group("group", 0);
    run_group("group_stall", 3);

    // Shortened gray frame with valid always high.
    do_reset();
    obs_q.delete(); exp_q.delete();
    pix_R = 8'd128; pix_G = 8'd128; pix_B = 8'd128;
    pix_valid = 1'b1;
    busy_cyc = 0; done_cnt = 0;
    pulse_start();
    wait_idle(2000);
    repeat (3) @(posedge Clock_50);
    #1;
    check_eq("frame_busy_cycles", 64'(busy_cyc), 64'(6 * int'(G) + 1));
    check_eq("frame_done_count", 64'(done_cnt), 64'd1);
    check_eq("frame_last_y", 64'(obs_q.size() >= 4 ? obs_q[obs_q.size() - 3][33:16] : 18'h3FFFF),
             64'(2 * int'(G) - 1));
    push_gray_frame_exp();
    compare_writes("frame");

    // Mid-frame reset after 10 groups, asserted while a Y write is on the bus.
    do_reset();
    obs_q.delete(); exp_q.delete();
    pulse_start();
    wait_writes(41, 1000);
    check_eq("pre_rst_we_n", {63'd0, SRAM_we_n}, 64'd0);
    Reset = 1'b1;
    #1;
    check_eq("async_rst_we_n",  {63'd0, SRAM_we_n}, 64'd1);
    check_eq("async_rst_ready", {63'd0, pix_ready}, 64'd0);
    check_eq("async_rst_busy",  {63'd0, busy}, 64'd0);
    repeat (3) @(posedge Clock_50);
    #1 Reset = 1'b0;
    obs_q.delete();
    pulse_start();
    wait_writes(1, 200);
    check_eq("restart_first_write", 64'(obs_q.size() > 0 ? obs_q[0] : 34'h3FFFFFFFF),
             64'({18'd0, 16'h7E7E}));

    // start pulse mid-group while busy must be ignored.
    do_reset();
    obs_q.delete(); exp_q.delete();
    busy_cyc = 0; done_cnt = 0;
    pulse_start();
    wait_writes(22, 1000);
    pulse_start();
    wait_idle(2000);
    repeat (3) @(posedge Clock_50);
    #1;
    check_eq("busy_start_cycles", 64'(busy_cyc), 64'(6 * int'(G) + 1));
    check_eq("busy_start_done", 64'(done_cnt), 64'd1);
    push_gray_frame_exp();
    compare_writes("busy_start");
    pix_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
